// File: rtl/dp3_pkg.sv
// Shared types and constants for the three-sequence alignment DP engine:
// scheduler state encoding, default widths, and gap costs used by the recurrence units.
package dp3_pkg;

  localparam int IW_DEF = 8;
  localparam int SW_DEF = 12;

  localparam int G0 = 2;
  localparam int GE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/dp3_idx_counter.sv
// Three-axis raster index counter (k fastest, then j, then i) over the DP cube,
// with last-cell and boundary-cell flags.
module dp3_idx_counter
  import dp3_pkg::*;
#(
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  input  logic [IW-1:0] i_len_a,
  input  logic [IW-1:0] i_len_b,
  input  logic [IW-1:0] i_len_c,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic [IW-1:0] o_k,
  output logic          o_last,
  output logic          o_boundary
);

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_advance) begin
      // Carry ripples k -> j -> i so every neighbour of a cell is issued before it.
      if (r_k < i_len_c) begin
        r_k <= r_k + IW'(1);
      end else begin
        r_k <= '0;
        if (r_j < i_len_b) begin
          r_j <= r_j + IW'(1);
        end else begin
          r_j <= '0;
          r_i <= r_i + IW'(1);
        end
      end
    end
  end

  assign o_i        = r_i;
  assign o_j        = r_j;
  assign o_k        = r_k;
  assign o_last     = (r_i == i_len_a) && (r_j == i_len_b) && (r_k == i_len_c);
  assign o_boundary = (r_i == '0) || (r_j == '0) || (r_k == '0);

endmodule

// File: rtl/dp3_cell_scheduler.sv
// Issues every cell of the DP cube to the cell datapath one at a time, waits for each
// result, and captures the final cell's score as the alignment score.
module dp3_cell_scheduler
  import dp3_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int SW = SW_DEF,
  parameter int CW = 3*IW+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IW-1:0]        len_a,
  input  logic [IW-1:0]        len_b,
  input  logic [IW-1:0]        len_c,
  output logic                 busy,
  output logic                 done,
  output logic                 cell_valid,
  input  logic                 cell_ready,
  output logic [IW-1:0]        cell_i,
  output logic [IW-1:0]        cell_j,
  output logic [IW-1:0]        cell_k,
  output logic                 cell_boundary,
  input  logic                 res_valid,
  input  logic signed [SW-1:0] res_score,
  output logic signed [SW-1:0] final_score,
  output logic [CW-1:0]        cell_count,
  output logic                 proto_err
);

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_len_a;
  logic [IW-1:0]        r_len_b;
  logic [IW-1:0]        r_len_c;
  logic signed [SW-1:0] r_final;
  logic [CW-1:0]        r_count;
  logic                 r_perr;
  logic                 w_last;
  logic                 w_boundary;
  logic                 w_clear;
  logic                 w_res_ok;
  logic                 w_advance;

  assign w_clear   = (r_state == IDLE) && start;
  assign w_res_ok  = (r_state == WAIT) && res_valid;
  assign w_advance = w_res_ok && !w_last;

  dp3_idx_counter #(.IW(IW)) u_idx (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .i_len_a    (r_len_a),
    .i_len_b    (r_len_b),
    .i_len_c    (r_len_c),
    .o_i        (cell_i),
    .o_j        (cell_j),
    .o_k        (cell_k),
    .o_last     (w_last),
    .o_boundary (w_boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = (r_state != IDLE);
    done          = (r_state == FIN);
    cell_valid    = (r_state == ISSUE);
    cell_boundary = (r_state == ISSUE) && w_boundary;
    case (r_state)
      IDLE:    if (start)      w_next = ISSUE;
      ISSUE:   if (cell_ready) w_next = WAIT;
      WAIT:    if (res_valid)  w_next = w_last ? FIN : ISSUE;
      FIN:                     w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // Lengths are frozen for the whole run; a start while busy never reaches here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_a <= '0;
      r_len_b <= '0;
      r_len_c <= '0;
    end else if (w_clear) begin
      r_len_a <= len_a;
      r_len_b <= len_b;
      r_len_c <= len_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_final <= '0;
    end else if (w_clear) begin
      r_count <= '0;
      r_final <= '0;
    end else if (w_res_ok) begin
      r_count <= r_count + CW'(1);
      if (w_last) r_final <= res_score;
    end
  end

  // A stray result outside WAIT wins over the clear from a coincident start.
  always_ff @(posedge clk) begin
    if (rst)                                r_perr <= 1'b0;
    else if (res_valid && r_state != WAIT)  r_perr <= 1'b1;
    else if (w_clear)                       r_perr <= 1'b0;
  end

  assign final_score = r_final;
  assign cell_count  = r_count;
  assign proto_err   = r_perr;

endmodule

// File: tb/tb_dp3_cell_scheduler.sv
// Directed bench for dp3_cell_scheduler: a table of runs, each driven by a simple
// datapath responder with optional stall, stray-result, restart and reset injections.
module tb_dp3_cell_scheduler;

  localparam int IW = 8;
  localparam int SW = 12;
  localparam int CW = 3*IW+1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [IW-1:0]        len_a, len_b, len_c;
  logic                 busy, done, cell_valid, cell_ready, cell_boundary;
  logic [IW-1:0]        cell_i, cell_j, cell_k;
  logic                 res_valid;
  logic signed [SW-1:0] res_score;
  logic signed [SW-1:0] final_score;
  logic [CW-1:0]        cell_count;
  logic                 proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp3_cell_scheduler #(.IW(IW), .SW(SW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len_a         (len_a),
    .len_b         (len_b),
    .len_c         (len_c),
    .busy          (busy),
    .done          (done),
    .cell_valid    (cell_valid),
    .cell_ready    (cell_ready),
    .cell_i        (cell_i),
    .cell_j        (cell_j),
    .cell_k        (cell_k),
    .cell_boundary (cell_boundary),
    .res_valid     (res_valid),
    .res_score     (res_score),
    .final_score   (final_score),
    .cell_count    (cell_count),
    .proto_err     (proto_err)
  );

  typedef struct {
    int la, lb, lc;
    int stall_idx, stall_n;
    int proto_idx, restart_idx, rst_idx;
    int sbase;
    int exp_count, exp_final, exp_cyc, exp_perr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, longint'({busy, done, cell_valid, cell_boundary, proto_err}), 0);
    chk({tag, "_idx"}, longint'({cell_i, cell_j, cell_k}), 0);
    chk({tag, "_final"}, longint'(final_score), 0);
    chk({tag, "_count"}, longint'(cell_count), 0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [IW-1:0] qi[$];
    logic [IW-1:0] qj[$];
    logic [IW-1:0] qk[$];
    int  n = 0;
    int  stall_left = v.stall_n;
    int  done_cyc = 0;
    bit  in_wait = 0, proto_pending = 0, proto_used = 0, restarted = 0, busy_ok = 1;
    logic bnd;
    for (int a = 0; a <= v.la; a++)
      for (int b = 0; b <= v.lb; b++)
        for (int c = 0; c <= v.lc; c++) begin
          qi.push_back(IW'(a));
          qj.push_back(IW'(b));
          qk.push_back(IW'(c));
        end
    len_a = IW'(v.la);
    len_b = IW'(v.lb);
    len_c = IW'(v.lc);
    start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start      = 1'b0;
      res_valid  = 1'b0;
      cell_ready = 1'b0;
      if (!busy) busy_ok = 0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (proto_pending) begin
        chk($sformatf("v%0d_proto_cnt", id), longint'(cell_count), n);
        chk($sformatf("v%0d_proto_flag", id), longint'(proto_err), 1);
        proto_pending = 0;
      end
      if (in_wait) begin
        chk($sformatf("v%0d_wait_nvalid", id), longint'(cell_valid), 0);
        if (v.rst_idx == n) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk_reset($sformatf("v%0d_midrst", id));
          return;
        end
        res_valid = 1'b1;
        res_score = SW'(v.sbase - n);
        n++;
        in_wait = 0;
      end else if (cell_valid) begin
        if (n < qi.size()) begin
          bnd = (qi[n] == 0) || (qj[n] == 0) || (qk[n] == 0);
          chk($sformatf("v%0d_cell%0d", id, n),
              longint'({cell_i, cell_j, cell_k, cell_boundary}),
              longint'({qi[n], qj[n], qk[n], bnd}));
        end else begin
          chk($sformatf("v%0d_extra_issue", id), n, qi.size() - 1);
        end
        if (n == v.proto_idx && !proto_used) begin
          res_valid     = 1'b1;
          res_score     = SW'(77);
          proto_used    = 1;
          proto_pending = 1;
        end else if (n == v.stall_idx && stall_left > 0) begin
          stall_left--;
        end else begin
          cell_ready = 1'b1;
          in_wait    = 1;
        end
        if (n == v.restart_idx && !restarted) begin
          start     = 1'b1;
          len_a     = 8'd3;
          len_b     = 8'd3;
          len_c     = 8'd3;
          restarted = 1;
        end
      end else begin
        chk($sformatf("v%0d_no_issue", id), longint'(cell_valid), 1);
      end
    end
    chk($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_cyc);
    chk($sformatf("v%0d_results", id), n, v.exp_count);
    chk($sformatf("v%0d_count", id), longint'(cell_count), v.exp_count);
    chk($sformatf("v%0d_final", id), longint'(final_score), v.exp_final);
    chk($sformatf("v%0d_perr", id), longint'(proto_err), v.exp_perr);
    chk($sformatf("v%0d_busy_hold", id), busy_ok, 1);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), longint'({done, busy}), 0);
    chk($sformatf("v%0d_final_hold", id), longint'(final_score), v.exp_final);
  endtask

  initial begin
    //          la lb lc stl sn prt rsa rsi sbase cnt  final cyc perr
    vecs[0] = '{0, 0, 0, -1, 0, -1, -1, -1,  -5,  1,   -5,   3, 0};
    vecs[1] = '{1, 1, 1, -1, 0, -1, -1, -1,  -1,  8,   -8,  17, 0};
    vecs[2] = '{1, 1, 1,  1, 5, -1, -1, -1,  -1,  8,   -8,  22, 0};
    vecs[3] = '{1, 1, 1, -1, 0,  2, -1, -1,  -1,  8,   -8,  18, 1};
    vecs[4] = '{1, 0, 2, -1, 0, -1,  1, -1,  -1,  6,   -6,  13, 0};
    vecs[5] = '{2, 0, 0, -1, 0, -1, -1, -1, 100,  3,   98,   7, 0};
    vecs[6] = '{1, 2, 3, -1, 0, -1, -1, -1,  -1, 24,  -24,  49, 0};
    vecs[7] = '{3, 0, 2, -1, 0, -1, -1, -1,  -1, 12,  -12,  25, 0};
    vecs[8] = '{2, 3, 1, -1, 0,  0, -1,  2,  -1,  0,    0,   0, 0};
    vecs[9] = '{0, 0, 1, -1, 0, -1, -1, -1,  -1,  2,   -2,   5, 0};

    rst        = 1'b1;
    start      = 1'b0;
    len_a      = '0;
    len_b      = '0;
    len_c      = '0;
    cell_ready = 1'b0;
    res_valid  = 1'b0;
    res_score  = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("idle_stray_res", longint'({proto_err, cell_count}), longint'({1'b1, CW'(0)}));

    for (int t = 0; t < 10; t++) begin
      run_vec(t, vecs[t]);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp3_cell_scheduler.md
# dp3_cell_scheduler

Sequencer for the three-sequence alignment DP cube. It walks every cell (i,j,k) of the (len_a+1)×(len_b+1)×(len_c+1) lattice in dependency-safe raster order and issues each cell to the cell datapath, which holds the M/Ix/Iy/Iz/Ixy/Iyz/Ixz recurrence units. It keeps exactly one cell outstanding and waits for the datapath result before issuing the next. It captures the score of the final cell (len_a,len_b,len_c) as the alignment score.

## Interface
Parameters
- IW, 8, index width; each of len_a/len_b/len_c ranges 0..2^IW−1
- SW, 12, signed score width; matches the recurrence units
- CW, 3*IW+1, width of the completed-cell counter

Ports
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; latches lengths and begins a run when idle
- len_a, len_b, len_c  in  IW each  sequence lengths
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse when the final result has been captured
- cell_valid  out  1  issue request to the datapath
- cell_ready  in  1  datapath accepts; a transfer occurs when cell_valid && cell_ready
- cell_i, cell_j, cell_k  out  IW each  coordinates of the issued cell
- cell_boundary  out  1  high when any coordinate is 0, so the datapath applies init values
- res_valid  in  1  datapath result strobe for the outstanding cell
- res_score  in  SW signed  result of the outstanding cell
- final_score  out  SW signed  score of the last cell; holds until the next accepted start
- cell_count  out  CW  number of completed cells in the current or most recent run
- proto_err  out  1  sticky flag; res_valid arrived with no cell outstanding

## Operation
- Reset values: FSM=IDLE; busy, done, cell_valid, cell_boundary, proto_err = 0; cell_i/j/k = 0; final_score = 0; cell_count = 0.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE: on start, latch the lengths, set cell index to (0,0,0), clear cell_count and proto_err, then go to ISSUE. start while not IDLE is ignored.
- ISSUE: cell_valid=1 with stable cell_i/j/k and cell_boundary until the transfer. On transfer, go to WAIT.
- WAIT: cell_valid=0. On res_valid, cell_count += 1.
  - If the index equals (len_a,len_b,len_c), register res_score into final_score and go to FIN.
  - Otherwise advance the index and go to ISSUE.
- Index advance order: k fastest, then j, then i. The step rule is:
  - if k<len_c, then k+1;
  - else k=0, and if j<len_b, then j+1;
  - else j=0 and i+1.
- This order guarantees that all seven neighbours (i−1/j−1/k−1 combinations) complete before a cell is issued.
- FIN: done=1 for exactly one cycle, then IDLE. busy is high in ISSUE, WAIT, FIN.
- res_valid in IDLE, ISSUE or FIN sets proto_err and is otherwise ignored: no count change, no state change.
- Zero lengths: all zero gives a single boundary cell (0,0,0), then done.
- Counter arithmetic is unsigned with no wrap. Max count is 2^(3*IW), which fits in CW. final_score is taken verbatim (signed SW).

## Timing
- start at cycle t → cell_valid high at t+1 with (0,0,0).
- With cell_ready and res_valid both held high, cell_valid is high at t+1 and t+3, and low at t+2.
  - Each cell costs 2 cycles minimum plus datapath latency.
- res_valid in the same cycle as entering WAIT is not possible. The earliest accepted res_valid is the cycle after the transfer.
- done is asserted at cycle r+1, where r is the cycle with res_valid for the last cell. final_score and cell_count are valid from r+1.
- rst mid-run takes priority on the next edge: everything returns to reset values, including proto_err. In-flight results are discarded.

## Structure
- Package dp3_pkg holds:
  - SW and IW defaults
  - the state enum {IDLE, ISSUE, WAIT, FIN}
  - gap constants G0=2, GE=1, shared with the recurrence units
- One sub-module, dp3_idx_counter: a 3-axis index counter with advance, clear, last (index == lengths) and boundary outputs. The FSM stays in the top module.

## Test plan
- Lengths (0,0,0), res_score=−5 → one issue at (0,0,0) with cell_boundary=1; done one cycle after res_valid; final_score=−5, cell_count=1.
- Lengths (1,1,1), ready and res_valid always high, res_score = −(cell_count) → issue order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1); cell_boundary=0 only on (1,1,1); final_score=−8; done at cycle 17 after start.
- cell_ready low for 5 cycles on cell (0,0,1) → cell_valid and the index stay stable throughout; there is no skip and no duplicate.
- res_valid pulsed while in ISSUE → proto_err=1 and stays set; cell_count is unchanged; the run completes normally.
- A second start while busy → ignored; the lengths are not re-latched.
- rst asserted in WAIT on cell (0,1,0) of a (2,3,1) run → next cycle all outputs are at reset values; a new start with (0,0,1) completes with cell_count=2.
